alu_share_ctrl: RTL and testbench

Round-robin arbiter and sequencer that shares the single combinational execute ALU between two requesters: port 0 is the main execute path and port 1 is the branch/compare unit. The block accepts one operation at a time through a valid/ready handshake and drives the ALU operand and opcode lines from registers. It captures the ALU result and flags, then holds the response until the owning requester accepts it. It also masks shift amounts and rejects undefined opcodes.

---
 rtl/alu_share_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational execute ALU between the main execute
// path (port 0) and the branch/compare unit (port 1), one operation in flight.
module alu_share_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_ans,
    output logic [2:0]       rsp_flag,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_ans,
    input  logic [2:0]       alu_flag,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, grant_q, err_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_ans_q;
    logic [3:0]       alu_op_q;
    logic [2:0]       rsp_flag_q;
    logic             rsp_err_q;

    logic             grant_valid, grant_sel, rsp_fire;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, sel_b_masked;
    logic             sel_illegal, sel_is_shift;

    // With both requesters valid, the one that did not win last time goes next.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_sel   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
        sel_op       = grant_sel ? req1_op : req0_op;
        sel_a        = grant_sel ? req1_a  : req0_a;
        sel_b        = grant_sel ? req1_b  : req0_b;
        sel_illegal  = (sel_op > 4'd8);
        sel_is_shift = (sel_op == 4'd6) || (sel_op == 4'd7) || (sel_op == 4'd8);
        sel_b_masked = sel_is_shift ? {{(WIDTH-SHAMT_W){1'b0}}, sel_b[SHAMT_W-1:0]} : sel_b;
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    state_d    = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp0_valid = ~grant_q;
                rsp1_valid = grant_q;
                rsp_fire   = grant_q ? rsp1_ready : rsp0_ready;
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any in-flight or unaccepted response without a handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            err_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_ans_q    <= '0;
            rsp_flag_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_valid) begin
                grant_q  <= grant_sel;
                err_q    <= sel_illegal;
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b_masked;
                alu_op_q <= sel_illegal ? 4'd0 : sel_op;
            end
            if (state_q == EXEC) begin
                rsp_ans_q  <= err_q ? '0 : alu_ans;
                rsp_flag_q <= err_q ? 3'b000 : alu_flag;
                rsp_err_q  <= err_q;
            end
            if (state_q == RESP && rsp_fire) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign rsp_ans  = rsp_ans_q;
    assign rsp_flag = rsp_flag_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU closing the loop.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_ans;
    logic [2:0]  rsp_flag;
    logic        rsp_err;
    logic [31:0] alu_a, alu_b, alu_ans;
    logic [3:0]  alu_op;
    logic [2:0]  alu_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic        seen_ready0, seen_ready1, seen_busy;
    logic [31:0] seen_alu_a, seen_alu_b;
    logic [3:0]  seen_alu_op;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_ans(rsp_ans), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_ans(alu_ans), .alu_flag(alu_flag), .busy(busy)
    );

    // Behavioural execute ALU: flags are {overflow, zero, sign or less-than}.
    always_comb begin
        logic ovf;
        ovf     = 1'b0;
        alu_ans = '0;
        case (alu_op)
            4'd0: begin alu_ans = alu_a + alu_b; ovf = (alu_a[31] == alu_b[31]) && (alu_ans[31] != alu_a[31]); end
            4'd1: begin alu_ans = alu_a - alu_b; ovf = (alu_a[31] != alu_b[31]) && (alu_ans[31] != alu_a[31]); end
            4'd2: alu_ans = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd3: alu_ans = alu_a & alu_b;
            4'd4: alu_ans = alu_a | alu_b;
            4'd5: alu_ans = alu_a ^ alu_b;
            4'd6: alu_ans = alu_a << alu_b[4:0];
            4'd7: alu_ans = alu_a >> alu_b[4:0];
            4'd8: alu_ans = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_ans = '0;
        endcase
        alu_flag = {ovf, alu_ans == 32'd0, (alu_op == 4'd2) ? alu_ans[0] : alu_ans[31]};
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one request at a negedge and steps to the first RESP cycle.
    task automatic issue(input logic port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        #1;
        seen_ready0 = req0_ready;
        seen_ready1 = req1_ready;
        @(posedge clk);
        @(negedge clk);
        if (port) req1_valid = 0; else req0_valid = 0;
        seen_busy   = busy;
        seen_alu_a  = alu_a;
        seen_alu_b  = alu_b;
        seen_alu_op = alu_op;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic port);
        if (port) rsp1_ready = 1; else rsp0_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 0;
        rsp1_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl got %b expected 000000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 68'd0) begin
            errors++; $display("[TB] FAIL reset_alu_regs got %h expected 0", {alu_a, alu_b, alu_op});
        end
        checks++;
        if ({rsp_ans, rsp_flag} !== 35'd0) begin
            errors++; $display("[TB] FAIL reset_rsp got %h expected 0", {rsp_ans, rsp_flag});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        issue(1'b0, 4'd0, 32'd5, 32'd3);
        checks++;
        if ({seen_ready0, seen_ready1} !== 2'b10) begin
            errors++; $display("[TB] FAIL add_ready got %b expected 10", {seen_ready0, seen_ready1});
        end
        checks++;
        if (seen_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL add_busy got %b expected 1", seen_busy);
        end
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL add_rsp_valid got %b expected 10", {rsp0_valid, rsp1_valid});
        end
        checks++;
        if ({rsp_ans, rsp_flag, rsp_err} !== {32'd8, 3'b000, 1'b0}) begin
            errors++; $display("[TB] FAIL add_result got %h/%b/%b expected 8/000/0", rsp_ans, rsp_flag, rsp_err);
        end
        accept(1'b0);
        checks++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL add_done got %b expected 00", {busy, rsp0_valid});
        end
    endtask

    task automatic test_flags();
        issue(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1);
        checks++;
        if ({seen_ready0, seen_ready1} !== 2'b01) begin
            errors++; $display("[TB] FAIL ovf_ready got %b expected 01", {seen_ready0, seen_ready1});
        end
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b01) begin
            errors++; $display("[TB] FAIL ovf_rsp_valid got %b expected 01", {rsp0_valid, rsp1_valid});
        end
        checks++;
        if ({rsp_ans, rsp_flag} !== {32'h8000_0000, 3'b101}) begin
            errors++; $display("[TB] FAIL ovf_result got %h/%b expected 80000000/101", rsp_ans, rsp_flag);
        end
        accept(1'b1);
        issue(1'b0, 4'd1, 32'd5, 32'd5);
        checks++;
        if ({rsp_ans, rsp_flag, rsp_err} !== {32'd0, 3'b010, 1'b0}) begin
            errors++; $display("[TB] FAIL sub_zero got %h/%b/%b expected 0/010/0", rsp_ans, rsp_flag, rsp_err);
        end
        accept(1'b0);
    endtask

    task automatic test_round_robin();
        apply_reset();
        req0_valid = 1; req0_op = 4'd0; req0_a = 32'd10; req0_b = 32'd1;
        req1_valid = 1; req1_op = 4'd1; req1_a = 32'd10; req1_b = 32'd1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = i[0];
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== {~g, g}) begin
                errors++; $display("[TB] FAIL rr_grant%0d got %b expected %b", i, {req0_ready, req1_ready}, {~g, g});
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
                errors++; $display("[TB] FAIL rr_exec%0d got %b expected 0000", i, {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({rsp0_valid, rsp1_valid, rsp_ans} !== {~g, g, (g ? 32'd9 : 32'd11)}) begin
                errors++; $display("[TB] FAIL rr_rsp%0d got %b%b/%0d expected %b%b/%0d", i, rsp0_valid, rsp1_valid, rsp_ans, ~g, g, g ? 9 : 11);
            end
            @(posedge clk);
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_shift();
        issue(1'b0, 4'd6, 32'd1, 32'd33);
        checks++;
        if ({seen_alu_b, seen_alu_op} !== {32'd1, 4'd6}) begin
            errors++; $display("[TB] FAIL sll_alu_b got %h/%h expected 1/6", seen_alu_b, seen_alu_op);
        end
        checks++;
        if ({rsp_ans, rsp_flag} !== {32'd2, 3'b000}) begin
            errors++; $display("[TB] FAIL sll_result got %h/%b expected 2/000", rsp_ans, rsp_flag);
        end
        accept(1'b0);
        issue(1'b0, 4'd8, 32'h8000_0000, 32'h24);
        checks++;
        if (seen_alu_b !== 32'd4) begin
            errors++; $display("[TB] FAIL sra_alu_b got %h expected 4", seen_alu_b);
        end
        checks++;
        if ({rsp_ans, rsp_flag} !== {32'hF800_0000, 3'b001}) begin
            errors++; $display("[TB] FAIL sra_result got %h/%b expected f8000000/001", rsp_ans, rsp_flag);
        end
        accept(1'b0);
        issue(1'b0, 4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F);
        checks++;
        if ({seen_alu_a, seen_alu_b, rsp_ans} !== {32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F}) begin
            errors++; $display("[TB] FAIL xor_unmasked got %h/%h/%h expected ff00ff00/0f0f0f0f/f00ff00f", seen_alu_a, seen_alu_b, rsp_ans);
        end
        accept(1'b0);
    endtask

    task automatic test_illegal();
        issue(1'b0, 4'hF, 32'd7, 32'd9);
        checks++;
        if (seen_alu_op !== 4'd0) begin
            errors++; $display("[TB] FAIL illegal_alu_op got %h expected 0", seen_alu_op);
        end
        checks++;
        if ({rsp0_valid, rsp_err, rsp_ans, rsp_flag} !== {1'b1, 1'b1, 32'd0, 3'b000}) begin
            errors++; $display("[TB] FAIL illegal_rsp got %b/%b/%h/%b expected 1/1/0/000", rsp0_valid, rsp_err, rsp_ans, rsp_flag);
        end
        accept(1'b0);
        checks++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL illegal_idle got %b expected 00", {busy, rsp0_valid});
        end
        issue(1'b0, 4'd3, 32'hF0, 32'h3C);
        checks++;
        if ({rsp_err, rsp_ans} !== {1'b0, 32'h30}) begin
            errors++; $display("[TB] FAIL err_clear got %b/%h expected 0/30", rsp_err, rsp_ans);
        end
        accept(1'b0);
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 4'd0, 32'd1, 32'd2);
        req1_valid = 1; req1_op = 4'd4; req1_a = 32'hF0; req1_b = 32'h0F;
        rsp1_ready = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({rsp0_valid, rsp1_valid, req1_ready, rsp_ans, rsp_err} !== {3'b100, 32'd3, 1'b0}) begin
                errors++; $display("[TB] FAIL hold%0d got %b%b%b/%h expected 100/3", i, rsp0_valid, rsp1_valid, req1_ready, rsp_ans);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rsp1_ready = 0;
        accept(1'b0);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL pending_grant got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp_ans} !== {1'b1, 32'hFF}) begin
            errors++; $display("[TB] FAIL pending_rsp got %b/%h expected 1/ff", rsp1_valid, rsp_ans);
        end
        accept(1'b1);
    endtask

    task automatic test_reset_mid_exec();
        req0_valid = 1; req0_op = 4'd0; req0_a = 32'd40; req0_b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, rsp0_valid, rsp1_valid, rsp_err, rsp_flag, rsp_ans} !== 39'd0) begin
            errors++; $display("[TB] FAIL midreset_rsp got %h expected 0", {busy, rsp0_valid, rsp1_valid, rsp_err, rsp_flag, rsp_ans});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 68'd0) begin
            errors++; $display("[TB] FAIL midreset_alu got %h expected 0", {alu_a, alu_b, alu_op});
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL midreset_idle got %b expected 00", {busy, rsp0_valid});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply_reset();
        test_reset();
        test_add();
        test_flags();
        test_round_robin();
        test_shift();
        test_illegal();
        test_back_to_back();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
